// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory-arbiter definitions: arbiter FSM encodings and counter width.
`ifndef MEM_ARBITER_PKG_SV
`define MEM_ARBITER_PKG_SV

package mem_arbiter_pkg;

  // Width of the fetch starvation counter (holds STARVE_MAX up to 15)
  localparam int unsigned STARVE_W = 4;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

endpackage

`endif

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter between instruction fetch and data load/store.
// Data has priority; a saturating starvation counter forces a fetch grant
// after STARVE_MAX consecutive data grants while fetch is waiting.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // data load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  // unified memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  logic [STARVE_W-1:0] r_starve_cnt;

  logic                r_if_gnt;
  logic                r_if_valid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_d_gnt;
  logic                r_d_valid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_if_req;
  logic                w_d_req;
  logic                w_ready;
  logic                w_starved;
  logic                w_pick_if;
  logic                w_pick_d;
  logic                w_arb_en;
  logic                w_grant_if;
  logic                w_grant_d;
  logic                w_done_if;
  logic                w_done_d;

  // A requester is not eligible again in the cycle its grant is visible
  assign w_if_req  = if_req & ~r_if_gnt;
  assign w_d_req   = d_req  & ~r_d_gnt;

  // Completion is never taken in the strobe cycle itself
  assign w_ready   = mem_ready & ~r_mem_en;

  // Priority: data first unless fetch has been passed over STARVE_MAX times
  assign w_starved = (r_starve_cnt == STARVE_W'(STARVE_MAX));
  assign w_pick_if = w_if_req & (~w_d_req | w_starved);
  assign w_pick_d  = w_d_req & ~w_pick_if;

  assign w_grant_if = w_arb_en & w_pick_if;
  assign w_grant_d  = w_arb_en & w_pick_d;
  assign w_done_if  = w_ready & (r_state == BUSY_IF);
  assign w_done_d   = w_ready & (r_state == BUSY_D);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: arbitrate when idle or when the current access completes
  always_comb begin
    w_state_next = r_state;
    w_arb_en     = 1'b0;
    case (r_state)
      IDLE:            w_arb_en = 1'b1;
      BUSY_IF, BUSY_D: w_arb_en = w_ready;
      default: begin
        w_arb_en     = 1'b0;
        w_state_next = IDLE;
      end
    endcase
    if (w_arb_en) begin
      if (w_pick_d) begin
        w_state_next = BUSY_D;
      end else if (w_pick_if) begin
        w_state_next = BUSY_IF;
      end else begin
        w_state_next = IDLE;
      end
    end
  end

  // Grant/strobe pulses, memory request latching and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_gnt    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_gnt     <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_gnt   <= w_grant_if;
      r_d_gnt    <= w_grant_d;
      r_mem_en   <= w_grant_if | w_grant_d;
      r_if_valid <= w_done_if;
      r_d_valid  <= w_done_d;
      if (w_done_if) begin
        r_if_rdata <= mem_rdata;
      end
      // stores complete without disturbing the last load result
      if (w_done_d && !r_mem_we) begin
        r_d_rdata <= mem_rdata;
      end
      if (w_grant_d) begin
        r_mem_addr  <= d_addr;
        r_mem_we    <= d_we;
        r_mem_wdata <= d_wdata;
      end else if (w_grant_if) begin
        r_mem_addr  <= if_addr;
        r_mem_we    <= 1'b0;
      end
    end
  end

  // Count data grants that bypassed a waiting fetch; reset when fetch wins or stops asking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!if_req || r_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_d_gnt && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
